// File: rtl/connect4_turn_ctrl.sv
// Turn sequencer for the Connect4 board. It validates each drop against per-column heights,
// strobes the board, waits for the win logic to settle, then passes the turn or ends the game.
module connect4_turn_ctrl #(
    parameter int unsigned COLS          = 7,
    parameter int unsigned ROWS          = 6,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TURN_TIMEOUT  = 50,
    parameter int unsigned TW            = $clog2(TURN_TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    column,
    input  logic          load_btn,
    input  logic          board_win,
    output logic          board_clr,
    output logic          load_pulse,
    output logic [2:0]    load_col,
    output logic          player,
    output logic          invalid,
    output logic          timeout,
    output logic [TW-1:0] time_left,
    output logic          game_over,
    output logic [1:0]    winner
);

    localparam int unsigned HW = $clog2(ROWS + 1);
    localparam int unsigned MW = $clog2(COLS * ROWS + 1);
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitMove,
        StDrop,
        StSettle,
        StCheck,
        StGameOver
    } state_e;

    state_e        state;
    logic [HW-1:0] height [COLS];
    logic [MW-1:0] moves;
    logic [SW-1:0] settle_cnt;
    logic          load_btn_q;

    logic          btn_edge;
    logic          col_ok;
    logic [HW-1:0] col_h;
    logic          move_ok;

    always_comb begin
        btn_edge = load_btn & ~load_btn_q;
        col_ok   = 32'(column) < COLS;
        col_h    = col_ok ? height[column] : '0;
        move_ok  = btn_edge & col_ok & (32'(col_h) < ROWS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            moves      <= '0;
            settle_cnt <= '0;
            load_btn_q <= 1'b0;
            board_clr  <= 1'b0;
            load_pulse <= 1'b0;
            load_col   <= '0;
            player     <= 1'b0;
            invalid    <= 1'b0;
            timeout    <= 1'b0;
            time_left  <= '0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            for (int unsigned c = 0; c < COLS; c++) height[c] <= '0;
        end else begin
            load_btn_q <= load_btn;
            board_clr  <= 1'b0;
            load_pulse <= 1'b0;
            invalid    <= 1'b0;
            timeout    <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        board_clr <= 1'b1;
                        player    <= 1'b0;
                        time_left <= TW'(TURN_TIMEOUT);
                        state     <= StWaitMove;
                    end
                end
                StWaitMove: begin
                    // A valid move beats an expiring timer in the same cycle.
                    if (move_ok) begin
                        load_col   <= column;
                        load_pulse <= 1'b1;
                        state      <= StDrop;
                        if (time_left != '0) time_left <= time_left - 1'b1;
                    end else if (time_left == '0) begin
                        timeout   <= 1'b1;
                        player    <= ~player;
                        time_left <= TW'(TURN_TIMEOUT);
                    end else begin
                        time_left <= time_left - 1'b1;
                    end
                    if (btn_edge && !move_ok) invalid <= 1'b1;
                end
                StDrop: begin
                    height[load_col] <= height[load_col] + 1'b1;
                    moves            <= moves + 1'b1;
                    settle_cnt       <= SW'(SETTLE_CYCLES - 1);
                    state            <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt == '0) state <= StCheck;
                    else settle_cnt <= settle_cnt - 1'b1;
                end
                StCheck: begin
                    if (board_win) begin
                        winner    <= {player, ~player};
                        game_over <= 1'b1;
                        state     <= StGameOver;
                    end else if (32'(moves) == COLS * ROWS) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= StGameOver;
                    end else begin
                        player    <= ~player;
                        time_left <= TW'(TURN_TIMEOUT);
                        state     <= StWaitMove;
                    end
                end
                StGameOver: begin
                    if (start) begin
                        board_clr <= 1'b1;
                        moves     <= '0;
                        winner    <= 2'b00;
                        game_over <= 1'b0;
                        player    <= 1'b0;
                        time_left <= TW'(TURN_TIMEOUT);
                        state     <= StWaitMove;
                        for (int unsigned c = 0; c < COLS; c++) height[c] <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
